// File: rtl/i2s_encoder_if.sv
// Sample-pair handshake between an upstream audio source and the I2S transmitter.
interface i2s_encoder_if;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_encoder.sv
// Master-mode I2S transmitter: 16-bit stereo pairs in via valid/ready, BCK/LRCK/DATA out.
// 32 BCK per frame, MSB first, data delayed one BCK after LRCK; a starved frame repeats the last pair.
module i2s_encoder #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         clock,
    input  logic         reset,
    i2s_encoder_if.slave smp,
    output logic         underrun,
    output logic         i2s_bck,
    output logic         i2s_lrck,
    output logic         i2s_data
);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned SLOT_W  = 5;
    localparam int unsigned FRAME_W = 32;

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               bck_q, bck_d;
    logic               lrck_q, lrck_d;
    logic               data_q, data_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [FRAME_W-1:0] frame_sr_q, frame_sr_d;
    logic [FRAME_W-1:0] pend_q, pend_d;
    logic [FRAME_W-1:0] last_q, last_d;
    logic               full_q, full_d;
    logic               ready_q, ready_d;
    logic               underrun_q, underrun_d;

    logic               tick;
    logic               fall;
    logic               load;
    logic               accept;
    logic [SLOT_W-1:0]  slot_nxt;
    logic [FRAME_W-1:0] load_word;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q  <= '0;
            bck_q      <= 1'b0;
            lrck_q     <= 1'b0;
            data_q     <= 1'b0;
            slot_q     <= '0;
            frame_sr_q <= '0;
            pend_q     <= '0;
            last_q     <= '0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bck_q      <= bck_d;
            lrck_q     <= lrck_d;
            data_q     <= data_d;
            slot_q     <= slot_d;
            frame_sr_q <= frame_sr_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        fall      = tick & bck_q;
        slot_nxt  = slot_q + SLOT_W'(1);
        load      = fall & (slot_q == '0);
        accept    = smp.sample_valid & ready_q;
        load_word = full_q ? pend_q : last_q;

        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        bck_d      = tick ? ~bck_q : bck_q;
        lrck_d     = lrck_q;
        data_d     = data_q;
        slot_d     = slot_q;
        frame_sr_d = frame_sr_q;
        pend_d     = pend_q;
        last_d     = last_q;
        full_d     = full_q;
        underrun_d = 1'b0;

        // Everything serial moves on the BCK falling edge so the receiver can sample on the rise.
        if (fall) begin
            slot_d = slot_nxt;
            lrck_d = slot_nxt[SLOT_W-1];
            if (load) begin
                frame_sr_d = load_word;
                data_d     = load_word[FRAME_W-1];
                if (full_q) begin
                    last_d = pend_q;
                    full_d = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                end
            end else begin
                frame_sr_d = {frame_sr_q[FRAME_W-2:0], 1'b0};
                data_d     = frame_sr_q[FRAME_W-2];
            end
        end

        // An accept coinciding with an empty-buffer load lands in the buffer for the next frame.
        if (accept) begin
            pend_d = {smp.sample_left, smp.sample_right};
            full_d = 1'b1;
        end

        ready_d = ~full_d;
    end

    assign smp.sample_ready = ready_q;
    assign underrun         = underrun_q;
    assign i2s_bck          = bck_q;
    assign i2s_lrck         = lrck_q;
    assign i2s_data         = data_q;
endmodule
